// File: rtl/ni_br_tx_queue_if.sv
// rtl/ni_br_tx_queue_if.sv - BrLite service type plus the CPU config / BrLite send handshake interface
package ni_br_pkg;
  typedef struct packed {
    logic [1:0]  service;
    logic [7:0]  ksvc;
    logic [15:0] target;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_out_t;
endpackage

interface ni_br_tx_queue_if #(
  parameter int ADDR_W = 5
);
  logic                      cfg_en_i;
  logic                      cfg_we_i;
  logic [ADDR_W-1:0]         cfg_addr_i;
  logic [31:0]               cfg_data_i;
  logic [31:0]               cfg_data_o;
  logic                      br_req_o;
  logic                      br_ack_i;
  ni_br_pkg::brlite_out_t    br_data_o;

  modport master (
    output cfg_en_i, cfg_we_i, cfg_addr_i, cfg_data_i, br_ack_i,
    input  cfg_data_o, br_req_o, br_data_o
  );

  modport slave (
    input  cfg_en_i, cfg_we_i, cfg_addr_i, cfg_data_i, br_ack_i,
    output cfg_data_o, br_req_o, br_data_o
  );
endinterface

// File: rtl/ni_br_tx_queue.sv
// rtl/ni_br_tx_queue.sv - DMNI BrLite MMR block with send queue, monitor pointers and IRQ aggregator
// Optional send watchdog enabled by defining DMNI_BR_TX_TIMEOUT_EN.
module ni_br_tx_queue #(
  parameter int N_MON    = 2,
  parameter int TX_DEPTH = 4,
  parameter int ADDR_W   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  ni_br_tx_queue_if.slave        bus,
  input  logic [1:0]             ext_irq_i,
  output logic                   irq_o,
  output logic [N_MON-1:0][31:0] br_mon_ptrs_o
);
  import ni_br_pkg::*;

  localparam int PW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_e;

  state_e                state_q, state_d;
  brlite_out_t           mem [TX_DEPTH];
  brlite_out_t           stage_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q;
  logic                  ovf_q, pending_q, timeout;
  logic [5:0]            irq_mask_q, irq_status;
  logic [N_MON-1:0][31:0] mon_q;
  logic [31:0]           rd_data;
  logic                  wr_en, rd_en, full, empty, pop, push_req, do_push, clr_ovf;

  assign wr_en    = bus.cfg_en_i & bus.cfg_we_i;
  assign rd_en    = bus.cfg_en_i & ~bus.cfg_we_i;
  assign full     = (count_q == (PW+1)'(TX_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == S_REQ) & bus.br_ack_i;
  assign push_req = wr_en & (bus.cfg_addr_i == ADDR_W'(9)) & bus.cfg_data_i[0];
  // A push into a full queue survives only if the head leaves on the same edge.
  assign do_push  = push_req & (~full | pop);
  assign clr_ovf  = wr_en & (bus.cfg_addr_i == ADDR_W'(10)) & bus.cfg_data_i[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_REQ;
      S_REQ:   if (bus.br_ack_i) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign bus.br_req_o  = (state_q == S_REQ);
  assign bus.br_data_o = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= stage_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && full && !pop) ovf_q <= 1'b1;
      else if (clr_ovf)             ovf_q <= 1'b0;
    end
  end

`ifdef DMNI_BR_TX_TIMEOUT_EN
  logic [15:0] tx_timeout_q, tmo_cnt_q;
  logic        timeout_q, tmo_hit, clr_tmo, in_wait;

  assign in_wait = (state_q == S_REQ) & ~bus.br_ack_i;
  assign tmo_hit = in_wait & (tx_timeout_q != 16'h0) & (tmo_cnt_q + 16'd1 == tx_timeout_q);
  assign clr_tmo = wr_en & (bus.cfg_addr_i == ADDR_W'(10)) & bus.cfg_data_i[1];
  assign timeout = timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_timeout_q <= 16'hFFFF;
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      if (wr_en && bus.cfg_addr_i == ADDR_W'(11)) tx_timeout_q <= bus.cfg_data_i[15:0];
      // Saturate so a long stall never wraps back into a false match.
      if (in_wait) tmo_cnt_q <= (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
      else         tmo_cnt_q <= '0;
      if (tmo_hit)      timeout_q <= 1'b1;
      else if (clr_tmo) timeout_q <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_mask_q <= 6'h07;
      pending_q  <= 1'b0;
      stage_q    <= '0;
      mon_q      <= '0;
    end else if (wr_en) begin
      case (bus.cfg_addr_i)
        ADDR_W'(2): irq_mask_q       <= bus.cfg_data_i[5:0];
        ADDR_W'(3): pending_q        <= bus.cfg_data_i[0];
        ADDR_W'(4): stage_q.service  <= bus.cfg_data_i[1:0];
        ADDR_W'(5): stage_q.ksvc     <= bus.cfg_data_i[7:0];
        ADDR_W'(6): stage_q.target   <= bus.cfg_data_i[15:0];
        ADDR_W'(7): stage_q.producer <= bus.cfg_data_i[15:0];
        ADDR_W'(8): stage_q.payload  <= bus.cfg_data_i;
        default: ;
      endcase
      for (int i = 0; i < N_MON; i++)
        if (bus.cfg_addr_i == ADDR_W'(16 + i)) mon_q[i] <= bus.cfg_data_i;
    end
  end

  assign br_mon_ptrs_o = mon_q;
  assign irq_status    = {timeout, ovf_q, empty, pending_q, ext_irq_i};
  assign irq_o         = |(irq_status & irq_mask_q);

  always_comb begin
    rd_data = '0;
    case (bus.cfg_addr_i)
      ADDR_W'(0): rd_data[8:0]  = {5'(count_q), timeout, ovf_q, full, empty};
      ADDR_W'(1): rd_data[5:0]  = irq_status;
      ADDR_W'(2): rd_data[5:0]  = irq_mask_q;
      ADDR_W'(3): rd_data[0]    = pending_q;
      ADDR_W'(4): rd_data[1:0]  = stage_q.service;
      ADDR_W'(5): rd_data[7:0]  = stage_q.ksvc;
      ADDR_W'(6): rd_data[15:0] = stage_q.target;
      ADDR_W'(7): rd_data[15:0] = stage_q.producer;
      ADDR_W'(8): rd_data       = stage_q.payload;
`ifdef DMNI_BR_TX_TIMEOUT_EN
      ADDR_W'(11): rd_data[15:0] = tx_timeout_q;
`endif
      default: ;
    endcase
    for (int i = 0; i < N_MON; i++)
      if (bus.cfg_addr_i == ADDR_W'(16 + i)) rd_data = mon_q[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    bus.cfg_data_o <= '0;
    else if (rd_en) bus.cfg_data_o <= rd_data;
  end
endmodule
